// File: rtl/md_pkg.sv
// Shared definitions for the mul/div sharing logic: port count, unit encodings, FSM states.
package md_pkg;

   localparam int unsigned MD_NPORT = 2;

   localparam int unsigned MD_OP_WIDTH = 2;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

   localparam int unsigned MD_OUT_SEL_WIDTH = 2;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StHold
   } md_state_e;

endpackage

// File: rtl/md_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the port that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] eligible,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = eligible;
      if (&eligible) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/md_share_arbiter.sv
// Shares one mul/div unit between two requesters; buffers the unit's result pulse and
// returns it to the owning port with valid/ready handshaking.
module md_share_arbiter
   import md_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [MD_NPORT-1:0]                  req_valid,
   output logic [MD_NPORT-1:0]                  req_ready,
   input  logic [MD_NPORT*MD_OP_WIDTH-1:0]      req_op,
   input  logic [MD_NPORT*MD_OUT_SEL_WIDTH-1:0] req_out_sel,
   input  logic [MD_NPORT-1:0]                  req_in_1_signed,
   input  logic [MD_NPORT-1:0]                  req_in_2_signed,
   input  logic [MD_NPORT*XLEN-1:0]             req_in_1,
   input  logic [MD_NPORT*XLEN-1:0]             req_in_2,
   input  logic [MD_NPORT-1:0]                  kill,
   output logic [MD_NPORT-1:0]                  resp_valid,
   input  logic [MD_NPORT-1:0]                  resp_ready,
   output logic [XLEN-1:0]                      resp_result,
   output logic                                 md_req_valid,
   output logic [MD_OP_WIDTH-1:0]               md_req_op,
   output logic [MD_OUT_SEL_WIDTH-1:0]          md_req_out_sel,
   output logic                                 md_req_in_1_signed,
   output logic                                 md_req_in_2_signed,
   output logic [XLEN-1:0]                      md_req_in_1,
   output logic [XLEN-1:0]                      md_req_in_2,
   input  logic                                 md_req_ready,
   input  logic                                 md_resp_valid,
   input  logic [XLEN-1:0]                      md_resp_result
);

   md_state_e        state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic             killed_q, killed_d;
   logic [XLEN-1:0]  rbuf_q, rbuf_d;

   logic [MD_NPORT-1:0] eligible;
   logic [MD_NPORT-1:0] grant;
   logic                gidx;
   logic                owner_kill;

   assign eligible   = req_valid & ~kill;
   assign gidx       = grant[1];
   assign owner_kill = kill[owner_q];

   rr_arb2 u_rr_arb2 (
      .eligible   (eligible),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         killed_q     <= 1'b0;
         rbuf_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         killed_q     <= killed_d;
         rbuf_q       <= rbuf_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      owner_d            = owner_q;
      last_grant_d       = last_grant_q;
      killed_d           = killed_q;
      rbuf_d             = rbuf_q;
      req_ready          = '0;
      resp_valid         = '0;
      resp_result        = '0;
      md_req_valid       = 1'b0;
      md_req_op          = '0;
      md_req_out_sel     = '0;
      md_req_in_1_signed = 1'b0;
      md_req_in_2_signed = 1'b0;
      md_req_in_1        = '0;
      md_req_in_2        = '0;

      unique case (state_q)
         StIdle: begin
            // Outputs are forced low during reset so the unit sees no request while resetting.
            if ((|grant) && !reset) begin
               md_req_valid       = 1'b1;
               md_req_op          = gidx ? req_op[MD_OP_WIDTH +: MD_OP_WIDTH]
                                         : req_op[0 +: MD_OP_WIDTH];
               md_req_out_sel     = gidx ? req_out_sel[MD_OUT_SEL_WIDTH +: MD_OUT_SEL_WIDTH]
                                         : req_out_sel[0 +: MD_OUT_SEL_WIDTH];
               md_req_in_1_signed = req_in_1_signed[gidx];
               md_req_in_2_signed = req_in_2_signed[gidx];
               md_req_in_1        = gidx ? req_in_1[XLEN +: XLEN] : req_in_1[0 +: XLEN];
               md_req_in_2        = gidx ? req_in_2[XLEN +: XLEN] : req_in_2[0 +: XLEN];
               req_ready          = grant & {MD_NPORT{md_req_ready}};
               if (md_req_ready) begin
                  state_d      = StBusy;
                  owner_d      = gidx;
                  last_grant_d = gidx;
                  killed_d     = 1'b0;
               end
            end
         end
         StBusy: begin
            if (owner_kill) begin
               killed_d = 1'b1;
            end
            if (md_resp_valid) begin
               if (killed_q || owner_kill) begin
                  state_d = StIdle;
               end else begin
                  rbuf_d  = md_resp_result;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (!reset) begin
               resp_valid[owner_q] = 1'b1;
               resp_result         = rbuf_q;
            end
            if (resp_ready[owner_q] || owner_kill) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_md_share_arbiter.sv
// Scoreboard bench for md_share_arbiter with a behavioural mul/div unit model.
module tb_md_share_arbiter;
   import md_pkg::*;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]      req_valid, req_ready, kill, resp_valid, resp_ready;
   logic [3:0]      req_op, req_out_sel;
   logic [1:0]      req_in_1_signed, req_in_2_signed;
   logic [63:0]     req_in_1, req_in_2;
   logic [31:0]     resp_result;
   logic            md_req_valid, md_req_in_1_signed, md_req_in_2_signed;
   logic [1:0]      md_req_op, md_req_out_sel;
   logic [31:0]     md_req_in_1, md_req_in_2, md_resp_result;
   logic            md_req_ready, md_resp_valid;

   // Per-port stimulus fields
   logic [1:0]  t_valid;
   logic [1:0]  t_op [2];
   logic [1:0]  t_sel [2];
   logic        t_s1 [2];
   logic        t_s2 [2];
   logic [31:0] t_a [2];
   logic [31:0] t_b [2];
   logic [1:0]  rr_base, bp_rand;
   logic        bp_en;

   assign req_valid       = t_valid;
   assign req_op          = {t_op[1], t_op[0]};
   assign req_out_sel     = {t_sel[1], t_sel[0]};
   assign req_in_1_signed = {t_s1[1], t_s1[0]};
   assign req_in_2_signed = {t_s2[1], t_s2[0]};
   assign req_in_1        = {t_a[1], t_a[0]};
   assign req_in_2        = {t_b[1], t_b[0]};
   assign resp_ready      = bp_en ? bp_rand : rr_base;

   md_share_arbiter #(.XLEN(XLEN)) dut (
      .clk                (clk),
      .reset              (reset),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_op             (req_op),
      .req_out_sel        (req_out_sel),
      .req_in_1_signed    (req_in_1_signed),
      .req_in_2_signed    (req_in_2_signed),
      .req_in_1           (req_in_1),
      .req_in_2           (req_in_2),
      .kill               (kill),
      .resp_valid         (resp_valid),
      .resp_ready         (resp_ready),
      .resp_result        (resp_result),
      .md_req_valid       (md_req_valid),
      .md_req_op          (md_req_op),
      .md_req_out_sel     (md_req_out_sel),
      .md_req_in_1_signed (md_req_in_1_signed),
      .md_req_in_2_signed (md_req_in_2_signed),
      .md_req_in_1        (md_req_in_1),
      .md_req_in_2        (md_req_in_2),
      .md_req_ready       (md_req_ready),
      .md_resp_valid      (md_resp_valid),
      .md_resp_result     (md_resp_result)
   );

   logic [106:0] all_out;
   assign all_out = {req_ready, resp_valid, resp_result, md_req_valid, md_req_op, md_req_out_sel,
                     md_req_in_1_signed, md_req_in_2_signed, md_req_in_1, md_req_in_2};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Architectural mul/div result from plain 64-bit arithmetic.
   function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sel,
                                          input logic s1, input logic s2,
                                          input logic [31:0] a, input logic [31:0] b);
      longint      ea, eb;
      logic [63:0] v;
      ea = s1 ? longint'($signed(a)) : longint'(a);
      eb = s2 ? longint'($signed(b)) : longint'(b);
      if (op == MD_OP_MUL) begin
         v = ea * eb;
         return (sel == MD_OUT_HI) ? v[63:32] : v[31:0];
      end
      if (eb == 0) v = (sel == MD_OUT_REM || op == MD_OP_REM) ? {32'b0, a} : '1;
      else if (sel == MD_OUT_REM || op == MD_OP_REM) v = ea % eb;
      else v = ea / eb;
      return v[31:0];
   endfunction

   function automatic logic [31:0] exp_of(input int p);
      return md_ref(t_op[p], t_sel[p], t_s1[p], t_s2[p], t_a[p], t_b[p]);
   endfunction

   function automatic int lat_of(input int p);
      return (t_op[p] == MD_OP_MUL) ? 7 : 19;
   endfunction

   // Shared mul/div unit: MUL answers 6 cycles after handshake, DIV/REM 18.
   logic        u_busy;
   int          u_cnt;
   logic [31:0] u_res;
   assign md_req_ready   = ~u_busy;
   assign md_resp_valid  = u_busy && (u_cnt == 1);
   assign md_resp_result = md_resp_valid ? u_res : 32'hDEADBEEF;
   always @(posedge clk) begin
      if (reset) begin
         u_busy <= 1'b0;
         u_cnt  <= 0;
         u_res  <= '0;
      end else if (u_busy) begin
         u_cnt <= u_cnt - 1;
         if (u_cnt == 1) u_busy <= 1'b0;
      end else if (md_req_valid) begin
         u_busy <= 1'b1;
         u_cnt  <= (md_req_op == MD_OP_MUL) ? 6 : 18;
         u_res  <= md_ref(md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed,
                          md_req_in_1, md_req_in_2);
      end
   end

   typedef struct {
      int          port;
      logic [31:0] res;
      int          hs;
      int          lat;
   } exp_t;
   exp_t sb[$];
   bit   m_last;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic set_port(input int p, input logic [1:0] op, input logic [1:0] sel,
                           input logic s1, input logic s2, input logic [31:0] a,
                           input logic [31:0] b);
      t_op[p] = op; t_sel[p] = sel; t_s1[p] = s1; t_s2[p] = s2; t_a[p] = a; t_b[p] = b;
   endtask

   // Wait for the next request handshake, check it goes to port p, and record the expectation.
   task automatic wait_hs(input int p, input bit push, input logic [31:0] want_res,
                          input int lat, output int hs);
      bit got = 0;
      int n   = 0;
      hs = -1;
      while (!got && n < 200) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            got = 1;
            hs  = cyc;
            chk("grant_port", req_ready, 2'b01 << p);
            chk("md_req_valid", md_req_valid, 1);
            chk("md_req_in_1", md_req_in_1, t_a[p]);
            chk("md_req_in_2", md_req_in_2, t_b[p]);
            if (push) sb.push_back('{port: p, res: want_res, hs: cyc, lat: lat});
            m_last = p[0];
         end
         n++;
      end
      if (!got) chk("handshake_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || resp_valid != 2'b00) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   // Monitor: one-hot/zero checks, hold stability, latency and scoreboard compare.
   initial begin
      logic [1:0]  prev_v = 2'b00;
      logic [31:0] prev_r = '0;
      bit          prev_gone = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_v = 2'b00;
            prev_gone = 1'b0;
         end else begin
            chk("resp_onehot0", $onehot0(resp_valid), 1);
            if (resp_valid == 2'b00) chk("resp_result_zero", resp_result, 0);
            if (prev_v != 2'b00 && !prev_gone) begin
               chk("hold_valid_stable", resp_valid, prev_v);
               chk("hold_result_stable", resp_result, prev_r);
            end
            if (resp_valid != 2'b00) begin
               if (sb.size() == 0) begin
                  chk("unexpected_resp", resp_valid, 0);
               end else begin
                  if (prev_v == 2'b00) chk("resp_latency", cyc - sb[0].hs, sb[0].lat);
                  if ((resp_valid & kill) != 2'b00) begin
                     void'(sb.pop_front());
                  end else if ((resp_valid & resp_ready) != 2'b00) begin
                     e = sb.pop_front();
                     chk("resp_port", resp_valid, 2'b01 << e.port);
                     chk("resp_result", resp_result, e.res);
                  end
               end
            end
            prev_gone = (resp_valid & (resp_ready | kill)) != 2'b00;
            prev_v = resp_valid;
            prev_r = resp_result;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         bp_rand = 2'($urandom_range(0, 3));
      end
   end

   initial begin
      int hs0, hs1, c0, n;
      int winner;
      logic [1:0] mask;
      reset = 1'b1; t_valid = 2'b00; kill = 2'b00; rr_base = 2'b11; bp_en = 1'b0;
      bp_rand = 2'b00; m_last = 1'b1;
      for (int p = 0; p < 2; p++) set_port(p, MD_OP_MUL, MD_OUT_LO, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk) chk("reset_outputs", all_out, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk) chk("idle_outputs", all_out, 0);
      @(posedge clk); #1;

      // Contention right after reset: 0, then 1, then 0 again.
      set_port(0, MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd3, 32'd5);
      set_port(1, MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd11, 32'd13);
      t_valid = 2'b11;
      wait_hs(0, 1, 32'd15, 7, hs0);
      wait_hs(1, 1, 32'd143, 7, hs0);
      wait_hs(0, 1, 32'd15, 7, hs0);
      t_valid = 2'b00;
      drain();

      // Signed MUL 7 * -3, low half.
      set_port(0, MD_OP_MUL, MD_OUT_LO, 1, 1, 32'd7, 32'hFFFF_FFFD);
      c0 = cyc;
      t_valid = 2'b01;
      wait_hs(0, 1, 32'hFFFF_FFEB, 7, hs0);
      chk("mul_ready_cycle0", hs0, c0);
      t_valid = 2'b00;
      drain();

      // Unsigned DIV 100 / 7 on port 1.
      set_port(1, MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd100, 32'd7);
      t_valid = 2'b10;
      wait_hs(1, 1, 32'd14, 19, hs0);
      t_valid = 2'b00;
      drain();

      // Port 0 DIV killed in cycle 5 while port 1 waits.
      set_port(0, MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd500, 32'd9);
      t_valid = 2'b01;
      wait_hs(0, 0, 32'd0, 19, hs0);
      set_port(1, MD_OP_MUL, MD_OUT_HI, 1, 0, 32'h8000_0001, 32'hFFFF_FFFF);
      t_valid = 2'b10;
      repeat (4) @(posedge clk);
      #1 kill = 2'b01;
      @(posedge clk); #1 kill = 2'b00;
      wait_hs(1, 1, exp_of(1), lat_of(1), hs1);
      chk("kill_regrant_cycle", hs1, hs0 + 19);
      t_valid = 2'b00;
      drain();

      // Port 0 result held back; port 1 must wait until it is accepted.
      rr_base = 2'b10;
      set_port(0, MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd1234, 32'd5678);
      t_valid = 2'b01;
      wait_hs(0, 1, exp_of(0), 7, hs0);
      set_port(1, MD_OP_DIV, MD_OUT_REM, 1, 1, 32'hFFFF_FF9C, 32'd7);
      t_valid = 2'b10;
      n = 0;
      while (resp_valid[0] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("hold_resp_seen", resp_valid, 2'b01);
      repeat (10) begin
         @(negedge clk);
         chk("hold_blocks_port1", req_ready, 2'b00);
      end
      @(posedge clk); #1 rr_base = 2'b11;
      c0 = cyc;
      wait_hs(1, 1, exp_of(1), lat_of(1), hs1);
      chk("hold_release_grant", hs1, c0 + 1);
      t_valid = 2'b00;
      drain();

      // Reset in cycle 9 of a DIV.
      set_port(0, MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd1000, 32'd3);
      t_valid = 2'b01;
      wait_hs(0, 0, 32'd0, 19, hs0);
      t_valid = 2'b00;
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk) chk("reset_mid_outputs", all_out, 0);
      @(posedge clk); #1 reset = 1'b0;
      m_last = 1'b1;
      @(negedge clk) chk("post_reset_outputs", all_out, 0);
      repeat (25) begin
         @(negedge clk);
         chk("no_stale_resp", resp_valid, 0);
      end
      @(posedge clk); #1;
      set_port(0, MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd21, 32'd2);
      set_port(1, MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd9, 32'd9);
      t_valid = 2'b11;
      wait_hs(0, 1, 32'd42, 7, hs0);
      t_valid[0] = 1'b0;
      wait_hs(1, 1, 32'd81, 7, hs0);
      t_valid = 2'b00;
      drain();

      // Random traffic with response backpressure.
      bp_en = 1'b1;
      for (int it = 0; it < 30; it++) begin
         mask = 2'($urandom_range(1, 3));
         for (int p = 0; p < 2; p++) begin
            set_port(p, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
         end
         t_valid = mask;
         winner = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[1] ? 1 : 0);
         wait_hs(winner, 1, exp_of(winner), lat_of(winner), hs0);
         t_valid[winner] = 1'b0;
         if (mask == 2'b11) wait_hs(1 - winner, 1, exp_of(1 - winner), lat_of(1 - winner), hs1);
         t_valid = 2'b00;
         drain();
      end
      bp_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
